// File: rtl/serial_cmd_frame_decoder.sv
// Pops bytes from the RX fifo and validates SOF SOF SPACE LEN PAYLOAD[LEN] [CSUM] EOF EOF,
// exposing the payload, an error code and the count of bytes consumed.
module serial_cmd_frame_decoder #(
  parameter int         MAX_PAYLOAD_BYTES = 8,
  parameter logic [7:0] SOF_BYTE          = 8'hFF,
  parameter logic [7:0] SPACE_BYTE        = 8'h00,
  parameter logic [7:0] EOF_BYTE          = 8'hEE,
  parameter bit         CHECKSUM_EN       = 1'b0,
  parameter int         TIMEOUT_CYCLES    = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_ready,
  input  logic                           cmd_processed_received,
  input  logic                           fifo_empty,
  input  logic [7:0]                     fifo_data,
  output logic                           fifo_pop,
  output logic                           busy,
  output logic                           cmd_processed,
  output logic                           cmd_decode_success,
  output logic [2:0]                     cmd_error_code,
  output logic [7:0]                     cmd_bytes_processed,
  output logic [7:0]                     cmd_payload_len,
  output logic [8*MAX_PAYLOAD_BYTES-1:0] cmd_payload
);
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN = 8'(MAX_PAYLOAD_BYTES);
  localparam int            PW      = 8*MAX_PAYLOAD_BYTES;

  localparam logic [2:0] E_OK = 3'd0, E_SOF = 3'd1, E_SPACE = 3'd2, E_LEN = 3'd3,
                         E_CSUM = 3'd4, E_EOF = 3'd5, E_TIMEOUT = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_SOF1, S_SOF2, S_SPACE, S_LEN, S_PAYLOAD, S_CSUM, S_EOF1, S_EOF2, S_FLUSH, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          cap_q, cap_d;
  logic          rdy_q;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    len_q, len_d;
  logic [PW-1:0] pay_q, pay_d;
  logic [2:0]    err_q, err_d;
  logic          succ_q, succ_d;
  logic          busy_q, busy_d;
  logic          proc_q, proc_d;

  logic       start, reading, fail, done;
  logic [2:0] fail_code;

  assign start    = cmd_ready && !rdy_q;
  assign reading  = (state_q != S_IDLE) && (state_q != S_DONE);
  // Each byte takes an ISSUE cycle (pop) and a CAPTURE cycle (sample), so pops never abut.
  assign fifo_pop = reading && !cap_q && !fifo_empty;

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    to_cnt_d  = to_cnt_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    pay_d     = pay_q;
    err_d     = err_q;
    succ_d    = succ_q;
    busy_d    = busy_q;
    proc_d    = proc_q;
    fail      = 1'b0;
    fail_code = E_OK;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          pay_d    = '0;
          len_d    = '0;
          err_d    = E_OK;
          succ_d   = 1'b0;
          cnt_d    = '0;
          csum_d   = '0;
          to_cnt_d = '0;
          cap_d    = 1'b0;
          state_d  = S_SOF1;
        end
      end
      S_DONE: begin
        if (cmd_processed_received) begin
          proc_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        if (!cap_q) begin
          if (!fifo_empty) begin
            cap_d    = 1'b1;
            to_cnt_d = '0;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end else if (state_q == S_FLUSH) begin
            done = 1'b1;
          end else if (to_cnt_q == TO_LAST) begin
            err_d  = E_TIMEOUT;
            succ_d = 1'b0;
            done   = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end else begin
          cap_d = 1'b0;
          case (state_q)
            S_SOF1:  if (fifo_data != SOF_BYTE) begin fail = 1'b1; fail_code = E_SOF; end
                     else state_d = S_SOF2;
            S_SOF2:  if (fifo_data != SOF_BYTE) begin fail = 1'b1; fail_code = E_SOF; end
                     else state_d = S_SPACE;
            S_SPACE: if (fifo_data != SPACE_BYTE) begin fail = 1'b1; fail_code = E_SPACE; end
                     else state_d = S_LEN;
            S_LEN: begin
              if (fifo_data == 8'd0 || fifo_data > MAX_LEN) begin
                fail      = 1'b1;
                fail_code = E_LEN;
              end else begin
                len_d   = fifo_data;
                csum_d  = fifo_data;
                idx_d   = '0;
                state_d = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              for (int i = 0; i < MAX_PAYLOAD_BYTES; i++)
                if (idx_q == 8'(i)) pay_d[8*i +: 8] = fifo_data;
              csum_d = csum_q ^ fifo_data;
              idx_d  = idx_q + 8'd1;
              if (idx_q == len_q - 8'd1) state_d = CHECKSUM_EN ? S_CSUM : S_EOF1;
            end
            S_CSUM:  if (fifo_data != csum_q) begin fail = 1'b1; fail_code = E_CSUM; end
                     else state_d = S_EOF1;
            S_EOF1:  if (fifo_data != EOF_BYTE) begin fail = 1'b1; fail_code = E_EOF; end
                     else state_d = S_EOF2;
            S_EOF2: begin
              if (fifo_data != EOF_BYTE) begin
                fail      = 1'b1;
                fail_code = E_EOF;
              end else begin
                succ_d = 1'b1;
                err_d  = E_OK;
                done   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
    // A bad frame drains the rest of itself before reporting.
    if (fail) begin
      err_d   = fail_code;
      succ_d  = 1'b0;
      state_d = S_FLUSH;
    end
    if (done) begin
      busy_d  = 1'b0;
      proc_d  = 1'b1;
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cap_q    <= 1'b0;
      rdy_q    <= 1'b0;
      to_cnt_q <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      pay_q    <= '0;
      err_q    <= E_OK;
      succ_q   <= 1'b0;
      busy_q   <= 1'b0;
      proc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      rdy_q    <= cmd_ready;
      to_cnt_q <= to_cnt_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      pay_q    <= pay_d;
      err_q    <= err_d;
      succ_q   <= succ_d;
      busy_q   <= busy_d;
      proc_q   <= proc_d;
    end
  end

  assign busy                = busy_q;
  assign cmd_processed       = proc_q;
  assign cmd_decode_success  = succ_q;
  assign cmd_error_code      = err_q;
  assign cmd_bytes_processed = cnt_q;
  assign cmd_payload_len     = len_q;
  assign cmd_payload         = pay_q;

endmodule

// File: tb/tb_serial_cmd_frame_decoder.sv
// Bench: two decoders (plain / checksum+short timeout) fed from queue fifos, checked
// against a frame-parsing reference model on every cycle of each decode.
module tb_serial_cmd_frame_decoder;
  localparam int MAXP = 8;

  typedef struct packed {
    logic [2:0]        err;
    logic              succ;
    logic [7:0]        len;
    logic [8*MAXP-1:0] pay;
    logic [7:0]        cnt;
    int                rem;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic              cmd_ready [2] = '{1'b0, 1'b0};
  logic              ack       [2] = '{1'b0, 1'b0};
  logic              fifo_empty[2] = '{1'b1, 1'b1};
  logic [7:0]        fifo_data [2] = '{8'h00, 8'h00};
  logic              fifo_pop  [2];
  logic              busy      [2];
  logic              proc      [2];
  logic              succ      [2];
  logic [2:0]        err       [2];
  logic [7:0]        cnt       [2];
  logic [7:0]        plen      [2];
  logic [8*MAXP-1:0] pay       [2];

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  exp_t exp_r[2];
  bit   running[2] = '{0, 0};
  bit   hold[2]    = '{0, 0};
  bit   prev_pop[2] = '{0, 0};
  int   checks = 0;
  int   errors = 0;

  serial_cmd_frame_decoder dut_a (
    .clk(clk), .rst(rst), .cmd_ready(cmd_ready[0]), .cmd_processed_received(ack[0]),
    .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]), .fifo_pop(fifo_pop[0]),
    .busy(busy[0]), .cmd_processed(proc[0]), .cmd_decode_success(succ[0]),
    .cmd_error_code(err[0]), .cmd_bytes_processed(cnt[0]), .cmd_payload_len(plen[0]),
    .cmd_payload(pay[0]));

  serial_cmd_frame_decoder #(.CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(64)) dut_b (
    .clk(clk), .rst(rst), .cmd_ready(cmd_ready[1]), .cmd_processed_received(ack[1]),
    .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]), .fifo_pop(fifo_pop[1]),
    .busy(busy[1]), .cmd_processed(proc[1]), .cmd_decode_success(succ[1]),
    .cmd_error_code(err[1]), .cmd_bytes_processed(cnt[1]), .cmd_payload_len(plen[1]),
    .cmd_payload(pay[1]));

  // RX fifo: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (fifo_pop[0] && fq0.size() > 0) fifo_data[0] <= fq0.pop_front();
    if (fifo_pop[1] && fq1.size() > 0) fifo_data[1] <= fq1.pop_front();
    fifo_empty[0] <= (fq0.size() == 0);
    fifo_empty[1] <= (fq1.size() == 0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, ex);
    end
  endtask

  // Reference: parse the byte list the fifo holds at start (fifo is static during a decode).
  function automatic exp_t model(input logic [7:0] s[$], input bit ce);
    exp_t e;
    int n = s.size();
    int pos = 0;
    int st = 0;
    int idx = 0;
    int code;
    logic [7:0] b;
    logic [7:0] cs = 8'h00;
    e.err = 3'd0; e.succ = 1'b0; e.len = 8'h00; e.pay = '0; e.cnt = 8'h00; e.rem = 0;
    while (pos < n) begin
      b = s[pos];
      pos++;
      code = 0;
      case (st)
        0, 1: if (b != 8'hFF) code = 1; else st++;
        2: if (b != 8'h00) code = 2; else st = 3;
        3: if (b == 8'h00 || b > 8'(MAXP)) code = 3;
           else begin e.len = b; cs = b; idx = 0; st = 4; end
        4: begin
          e.pay[idx*8 +: 8] = b;
          cs = cs ^ b;
          idx++;
          if (idx == int'(e.len)) st = ce ? 5 : 6;
        end
        5: if (b != cs) code = 4; else st = 6;
        6: if (b != 8'hEE) code = 5; else st = 7;
        default: begin
          if (b != 8'hEE) code = 5;
          else begin
            e.succ = 1'b1; e.cnt = 8'(pos); e.rem = n - pos;
            return e;
          end
        end
      endcase
      if (code != 0) begin
        e.err = 3'(code);
        e.cnt = (n > 255) ? 8'hFF : 8'(n);
        return e;
      end
    end
    e.err = 3'd6;
    e.cnt = 8'(pos);
    return e;
  endfunction

  always begin
    @(negedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (running[c]) begin
        chk("busy_during_decode", busy[c], 1);
        chk("pop_cadence", fifo_pop[c] && prev_pop[c], 0);
        chk("pop_when_empty", fifo_pop[c] && fifo_empty[c], 0);
      end
      if (hold[c]) begin
        chk("done_busy", busy[c], 0);
        chk("done_processed", proc[c], 1);
        chk("success", succ[c], exp_r[c].succ);
        chk("error_code", err[c], exp_r[c].err);
        chk("payload_len", plen[c], exp_r[c].len);
        chk("payload", pay[c], exp_r[c].pay);
        chk("bytes_processed", cnt[c], exp_r[c].cnt);
      end
      prev_pop[c] = fifo_pop[c];
    end
  end

  task automatic run(input int ch, input logic [7:0] s[$]);
    int i;
    @(negedge clk);
    foreach (s[k]) begin
      if (ch == 0) fq0.push_back(s[k]);
      else         fq1.push_back(s[k]);
    end
    exp_r[ch] = model(s, ch == 1);
    @(negedge clk);
    @(negedge clk);
    cmd_ready[ch] = 1'b1;
    @(negedge clk);
    cmd_ready[ch] = 1'b0;
    running[ch] = 1'b1;
    i = 0;
    while (!proc[ch] && i < 4000) begin
      cmd_ready[ch] = (i == 4);
      @(negedge clk);
      i++;
    end
    cmd_ready[ch] = 1'b0;
    running[ch] = 1'b0;
    chk("decode_finished", proc[ch], 1);
    chk("fifo_remaining", (ch == 0) ? fq0.size() : fq1.size(), exp_r[ch].rem);
    hold[ch] = 1'b1;
    cmd_ready[ch] = 1'b1;
    @(negedge clk);
    cmd_ready[ch] = 1'b0;
    @(negedge clk);
    ack[ch] = 1'b1;
    @(negedge clk);
    ack[ch] = 1'b0;
    hold[ch] = 1'b0;
    chk("ack_clears_processed", proc[ch], 0);
    chk("idle_not_busy", busy[ch], 0);
    if (ch == 0) fq0.delete(); else fq1.delete();
  endtask

  initial begin
    logic [7:0] s[$];
    int ch, L, mode, p;
    logic [7:0] b, cs;

    @(negedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("rst_outputs", {busy[c], proc[c], succ[c], err[c], plen[c], cnt[c], fifo_pop[c]}, 0);
      chk("rst_payload", pay[c], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    s = '{8'hFF, 8'hFF, 8'h00, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hEE, 8'hEE};
    run(0, s);
    chk("t1_success", succ[0], 1);
    chk("t1_err", err[0], 0);
    chk("t1_len", plen[0], 8'd6);
    chk("t1_payload", pay[0], 64'h0000_6655_4433_2211);
    chk("t1_count", cnt[0], 8'd12);

    s = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'hA5, 8'h5A, 8'hEE, 8'hEE};
    run(0, s);
    chk("t2_payload", pay[0], 64'h0000_0000_0000_5AA5);
    chk("t2_len_count", {plen[0], cnt[0]}, {8'd2, 8'd8});

    s = '{8'hFF, 8'h00, 8'h06, 8'h11, 8'hEE, 8'hEE};
    run(0, s);
    chk("t3_err_sof", {succ[0], err[0], cnt[0]}, {1'b0, 3'd1, 8'd6});

    s = '{8'hFF, 8'hFF, 8'h00, 8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
          8'h09, 8'hEE, 8'hEE};
    run(0, s);
    chk("t4_err_len", {err[0], cnt[0]}, {3'd3, 8'd15});

    s = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h02, 8'h01, 8'hEE, 8'hEE};
    run(1, s);
    chk("t5_csum_ok", {succ[1], err[1], cnt[1]}, {1'b1, 3'd0, 8'd9});
    s[6] = 8'h00;
    run(1, s);
    chk("t5_csum_bad", {succ[1], err[1]}, {1'b0, 3'd4});

    s = '{8'hFF, 8'hFF, 8'h00};
    run(1, s);
    chk("t6_timeout", {err[1], cnt[1]}, {3'd6, 8'd3});

    s = {};
    for (int k = 0; k < 300; k++) s.push_back(8'h12);
    run(0, s);
    chk("t7_count_saturates", {err[0], cnt[0]}, {3'd1, 8'hFF});

    for (int it = 0; it < 24; it++) begin
      ch = it % 2;
      L = $urandom_range(1, MAXP);
      cs = 8'(L);
      s = '{8'hFF, 8'hFF, 8'h00, 8'(L)};
      for (int j = 0; j < L; j++) begin
        b = 8'($urandom);
        s.push_back(b);
        cs = cs ^ b;
      end
      if (ch == 1) s.push_back(cs);
      s.push_back(8'hEE);
      s.push_back(8'hEE);
      mode = $urandom_range(0, 3);
      if (mode == 1 || mode == 2) begin
        p = $urandom_range(0, s.size() - 1);
        s[p] = s[p] ^ 8'($urandom_range(1, 255));
      end else if (mode == 3 && ch == 1) begin
        repeat ($urandom_range(1, 3)) void'(s.pop_back());
      end
      run(ch, s);
    end

    s = '{8'hFF, 8'hFF, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
          8'hEE, 8'hEE};
    @(negedge clk);
    foreach (s[k]) fq0.push_back(s[k]);
    @(negedge clk);
    @(negedge clk);
    cmd_ready[0] = 1'b1;
    @(negedge clk);
    cmd_ready[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_payload_busy", busy[0], 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {busy[0], proc[0], succ[0], err[0], plen[0], cnt[0], fifo_pop[0]}, 0);
    chk("rst_mid_payload", pay[0], 0);
    @(negedge clk);
    rst = 1'b0;
    fq0.delete();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish within 100000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
